mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for the supported instruction set.
- Drives all datapath enables and muxes, including `ext_op`, which selects sign or zero extension in the immediate extension unit.
- Waits on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]; sampled in DECODE
funct  input  6  IR[5:0]; sampled in DECODE
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (datapath ANDs with zero)
i_or_d  output  1  0=PC addresses memory, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  1=MDR to register file, 0=ALUOut
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=B, 01=4, 10=ext_imm, 11=ext_imm<<2
alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
ext_op  output  1  1=sign extend, 0=zero extend
state  output  4  current state encoding (debug)
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
illegal_op  output  1  sticky illegal-opcode flag (see feature)

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - state=FETCH(0), instr_count=0, illegal_op=0.
  - All write enables forced 0 while `rst_n` is low: pc_write, pc_write_cond, mem_write, ir_write, reg_write.
  - Other outputs take their FETCH decode.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12. Encodings 13-15 go to FETCH on the next clock.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_source=00.
  - ir_write and pc_write =1 only in the cycle mem_ready=1; then go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - Latch opcode/funct internally; the latched values drive all later states.
  - Outputs: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target).
  - Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 (lw) / 101011 (sw) -> MEM_ADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) / 001100 (andi) / 001101 (ori) -> I_EXEC
    - any other opcode -> illegal (see feature)
- ext_op: 0 when the latched opcode is andi or ori; 1 otherwise, including in FETCH and DECODE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Wait for mem_ready, then -> FETCH. mem_write stays high while waiting.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct:
  - 100000 -> add (010)
  - 100010 -> sub (110)
  - 100100 -> and (000)
  - 100101 -> or (001)
  - 101010 -> slt (111)
  - unknown funct -> add
  - Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_ctrl is add for addi, and for andi, or for ori -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Unlisted outputs are 0 in each state.
- instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. It wraps from all-ones to 0.
- Latency with mem_ready=1 every cycle: R-type 4, lw 5, sw 4, beq 3, j 3, addi/andi/ori 4 cycles.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE -> TRAP.
  - TRAP asserts no enables, sets illegal_op=1 (sticky) and holds until reset.
  - instr_count does not increment.
- Undefined:
  - An illegal opcode in DECODE -> FETCH, executed as a NOP; instr_count increments.
  - illegal_op tied 0 and TRAP unreachable.

Test Plan:
- Reset mid-MEM_READ: pull rst_n low asynchronously -> state=0, instr_count=0, all write enables 0 before the next clock edge.
- add (funct 100000), mem_ready=1 -> states 0,1,6,7,0. alu_ctrl=010 in R_EXEC, reg_write=1 and reg_dst=1 in R_WB, instr_count 0->1.
- lw with mem_ready low for 3 cycles in MEM_READ -> state holds at 3 for 3 cycles with mem_read=1 and i_or_d=1, then 4 (reg_write=1, mem_to_reg=1), then 0.
- ori then addi -> ext_op=0 in I_EXEC/I_WB for ori, ext_op=1 for addi. alu_ctrl 001 then 010.
- beq then j -> BRANCH: pc_write_cond=1, pc_source=01, alu_ctrl=110. JUMP: pc_write=1, pc_source=10. 3 cycles each.
- opcode 111111: with ILLEGAL_OP_TRAP_EN -> state=12, illegal_op=1, holds for 10 cycles. Without it -> FETCH next and instr_count increments.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (Moore style).
// Steps each instruction through fetch, decode, execute, memory and
// writeback. It drives every datapath enable and mux select, including
// ext_op, and counts retired instructions.
// Optional build macro ILLEGAL_OP_TRAP_EN: when it is defined, an illegal
// opcode sends the FSM to a sticky TRAP state. When it is not defined, an
// illegal opcode is retired as a NOP.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_source,
    output logic             ext_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur_state, nxt_state;
    logic [5:0] op_q, fn_q;
    logic       retire;
    logic       pw_raw, pwc_raw, mw_raw, irw_raw, rw_raw;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Capture opcode/funct in DECODE; later states rely only on these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 6'd0;
            fn_q <= 6'd0;
        end else if (cur_state == S_DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    // Sticky flag set on entry to TRAP, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      illegal_q <= 1'b0;
        else if (nxt_state == S_TRAP)    illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // Next-state logic and Moore output decode
    always_comb begin
        nxt_state  = cur_state;
        retire     = 1'b0;
        pw_raw     = 1'b0;
        pwc_raw    = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        pc_source  = 2'b00;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    irw_raw   = 1'b1;
                    pw_raw    = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                  nxt_state = S_R_EXEC;
                    OP_LW, OP_SW:              nxt_state = S_MEM_ADDR;
                    OP_BEQ:                    nxt_state = S_BRANCH;
                    OP_J:                      nxt_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  nxt_state = S_I_EXEC;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        nxt_state = S_TRAP;
`else
                        nxt_state = S_FETCH;
                        retire    = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                nxt_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                rw_raw     = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mw_raw = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (fn_q)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
                nxt_state = S_R_WB;
            end
            S_R_WB: begin
                rw_raw    = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pwc_raw   = 1'b1;
                pc_source = 2'b01;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pw_raw    = 1'b1;
                pc_source = 2'b10;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_ADD;
                endcase
                nxt_state = S_I_WB;
            end
            S_I_WB: begin
                rw_raw    = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: nxt_state = S_TRAP;
            default: nxt_state = S_FETCH;
        endcase
    end

    // Zero-extend only for logical immediates once the opcode has been latched
    assign ext_op = (cur_state == S_FETCH) || (cur_state == S_DECODE) ||
                    !((op_q == OP_ANDI) || (op_q == OP_ORI));

    // Write enables are held low for as long as reset is asserted
    assign pc_write      = pw_raw  & rst_n;
    assign pc_write_cond = pwc_raw & rst_n;
    assign mem_write     = mw_raw  & rst_n;
    assign ir_write      = irw_raw & rst_n;
    assign reg_write     = rw_raw  & rst_n;

    assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
// Runs random instruction streams with random memory wait states. Each
// instruction's expected state path comes from an instruction-level route
// table, and the expected outputs come from a per-state control table.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode, funct;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, illegal_op;
    logic [1:0]       alu_src_b, pc_source;
    logic [2:0]       alu_ctrl;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic [17:0]      ctrlVec;

    int checks = 0;
    int errors = 0;
    int modelCount = 0;
    logic trapSeen = 1'b0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_source(pc_source), .ext_op(ext_op), .state(state),
        .instr_count(instr_count), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign ctrlVec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_ctrl, pc_source, ext_op};

    // Single comparison point; every check is counted here
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word for a state, using the latched opcode/funct
    function automatic logic [17:0] expCtrl(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, eo;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        eo = !(st > 1 && (op == 6'b001100 || op == 6'b001101));
        case (st)
            0: begin mr = 1; sb = 2'b01; ac = 3'b010; pw = rdy; irw = rdy; end
            1: begin sb = 2'b11; ac = 3'b010; end
            2: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            3: begin mr = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iod = 1; end
            6: begin
                sa = 1;
                case (fn)
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'b010;
                endcase
            end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; ac = 3'b110; pwc = 1; ps = 2'b01; end
            9: begin pw = 1; ps = 2'b10; end
            10: begin
                sa = 1; sb = 2'b10;
                ac = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
            end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ac, ps, eo};
    endfunction

    // One clock cycle in the expected state: drive, check, advance
    task automatic applyStimulus(input int st, input logic rdy,
                                 input logic [5:0] op, input logic [5:0] fn);
        #1;
        opcode    = (st == 1) ? op : 6'($urandom);
        funct     = (st == 1) ? fn : 6'($urandom);
        mem_ready = rdy;
        #1;
        if (st == 12) trapSeen = 1'b1;
        checkOutput("state", 32'(state), 32'(st));
        checkOutput("ctrl", 32'(ctrlVec), 32'(expCtrl(st, op, fn, rdy)));
        checkOutput("count", 32'(instr_count), 32'(modelCount));
        checkOutput("illegal", 32'(illegal_op), 32'(trapSeen));
        @(posedge clk);
    endtask

    // Execute one instruction along its architectural route
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int memWaits);
        int path[$];
        int waits;
        bit trapped = 0;
        path = '{0, 1};
        case (op)
            6'b000000: path = '{0, 1, 6, 7};
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000, 6'b001100, 6'b001101: path = '{0, 1, 10, 11};
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                path = '{0, 1, 12};
                trapped = 1;
`endif
            end
        endcase
        foreach (path[k]) begin
            if (path[k] == 0) waits = $urandom_range(0, 2);
            else if (path[k] == 3 || path[k] == 5)
                waits = (memWaits >= 0) ? memWaits : $urandom_range(0, 3);
            else waits = -1;
            if (waits < 0) applyStimulus(path[k], 1'($urandom), op, fn);
            else for (int w = 0; w <= waits; w++) applyStimulus(path[k], (w == waits), op, fn);
        end
        if (trapped) begin
            for (int c = 0; c < 10; c++) applyStimulus(12, 1'($urandom), op, fn);
        end else begin
            modelCount = (modelCount + 1) % (1 << CNT_W);
        end
    endtask

    // Hold reset over a clock edge with mem_ready high, then release cleanly
    task automatic resetDut();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_count", 32'(instr_count), 32'd0);
        checkOutput("rst_ctrl", 32'(ctrlVec), 32'(expCtrl(0, 6'd0, 6'd0, 1'b0)));
        checkOutput("rst_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        modelCount = 0;
        trapSeen = 1'b0;
        @(posedge clk);
    endtask

    logic [5:0] legalOps [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101};
    logic [5:0] rFuncts  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        resetDut();

        // Directed: add, lw with 3 wait cycles, ori then addi, beq then j, unknown funct
        runInstr(6'b000000, 6'b100000, -1);
        runInstr(6'b100011, 6'd0, 3);
        runInstr(6'b001101, 6'd0, -1);
        runInstr(6'b001000, 6'd0, -1);
        runInstr(6'b000100, 6'd0, -1);
        runInstr(6'b000010, 6'd0, -1);
        runInstr(6'b000000, 6'b111111, -1);

        // Random instruction stream; counter width is small so it wraps
        for (int i = 0; i < 60; i++) begin
            op = legalOps[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rFuncts[$urandom_range(0, 4)];
            runInstr(op, fn, -1);
        end

        // Asynchronous reset while waiting in MEM_READ
        applyStimulus(0, 1'b1, 6'b100011, 6'd0);
        applyStimulus(1, 1'b0, 6'b100011, 6'd0);
        applyStimulus(2, 1'b0, 6'b100011, 6'd0);
        applyStimulus(3, 1'b0, 6'b100011, 6'd0);
        #3;
        resetDut();

        runInstr(6'b101011, 6'd0, 2);
        runInstr(6'b001100, 6'd0, -1);

        // Illegal opcode: traps or retires as NOP depending on build
        runInstr(6'b111111, 6'd0, -1);
`ifndef ILLEGAL_OP_TRAP_EN
        runInstr(6'b000000, 6'b100101, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
